// File: rtl/rx_frame_router.sv
// rx_frame_router: parses header/length/payload byte frames and forwards payload bytes to the weight or data FIFO.
// Define RX_FRAME_ROUTER_CHECKSUM_EN to append and verify an 8-bit payload sum byte.
module rx_frame_router #(
  parameter int W_DATA = 8,
  parameter int MAX_LEN = 512,
  parameter int TIMEOUT_CYC = 100000,
  parameter logic [W_DATA-1:0] HDR_WEIGHT = 8'hA1,
  parameter logic [W_DATA-1:0] HDR_DATA = 8'hA2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_dv,
  input  logic [W_DATA-1:0] i_rx_byte,
  output logic              o_rx_dv,
  output logic [W_DATA-1:0] o_data,
  output logic              o_fifo_sel_1,
  output logic              o_fifo_sel_2,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_frame_err
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
`ifdef RX_FRAME_ROUTER_CHECKSUM_EN
    CHK,
`endif
    PAYLOAD
  } state_t;
  state_t state;
  logic [7:0] len_hi;
  logic [15:0] len;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic hdr_w, hdr_d, timeout;
`ifdef RX_FRAME_ROUTER_CHECKSUM_EN
  logic [7:0] sum;
`endif
  assign len = {len_hi, i_rx_byte[7:0]};
  assign hdr_w = i_rx_byte == HDR_WEIGHT;
  assign hdr_d = i_rx_byte == HDR_DATA;
  assign timeout = state != IDLE && !i_rx_dv && tcnt == TW'(TIMEOUT_CYC - 1);
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      len_hi <= '0;
      cnt <= '0;
      tcnt <= '0;
      o_rx_dv <= 1'b0;
      o_data <= '0;
      o_fifo_sel_1 <= 1'b0;
      o_fifo_sel_2 <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef RX_FRAME_ROUTER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      o_rx_dv <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err <= 1'b0;
      tcnt <= (state == IDLE || i_rx_dv || timeout) ? '0 : tcnt + 1'b1;
      if (timeout) begin
        o_frame_err <= 1'b1;
        o_fifo_sel_1 <= 1'b0;
        o_fifo_sel_2 <= 1'b0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // sel drops here, one cycle after a frame's final payload strobe, unless a new header arrives
            o_fifo_sel_1 <= i_rx_dv && hdr_w;
            o_fifo_sel_2 <= i_rx_dv && hdr_d;
            if (i_rx_dv && (hdr_w || hdr_d)) begin
              state <= LEN_HI;
`ifdef RX_FRAME_ROUTER_CHECKSUM_EN
              sum <= '0;
`endif
            end
          end
          LEN_HI: if (i_rx_dv) begin
            len_hi <= i_rx_byte[7:0];
            state <= LEN_LO;
          end
          LEN_LO: if (i_rx_dv) begin
            if (len == 16'd0 || len > 16'(MAX_LEN)) begin
              o_frame_done <= len == 16'd0;
              o_frame_err <= len != 16'd0;
              o_fifo_sel_1 <= 1'b0;
              o_fifo_sel_2 <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= CW'(len);
              state <= PAYLOAD;
            end
          end
          PAYLOAD: if (i_rx_dv) begin
            o_rx_dv <= 1'b1;
            o_data <= i_rx_byte;
            cnt <= cnt - 1'b1;
`ifdef RX_FRAME_ROUTER_CHECKSUM_EN
            sum <= sum + i_rx_byte[7:0];
            if (cnt == CW'(1)) state <= CHK;
`else
            if (cnt == CW'(1)) begin
              o_frame_done <= 1'b1;
              state <= IDLE;
            end
`endif
          end
`ifdef RX_FRAME_ROUTER_CHECKSUM_EN
          CHK: if (i_rx_dv) begin
            o_frame_done <= i_rx_byte[7:0] == sum;
            o_frame_err <= i_rx_byte[7:0] != sum;
            o_fifo_sel_1 <= 1'b0;
            o_fifo_sel_2 <= 1'b0;
            state <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_frame_router.sv
// tb_rx_frame_router: directed vector table plus hand sequences for oversize, boundary, timeout and async reset.
module tb_rx_frame_router;
  localparam int TO = 16;
  logic i_clk = 1'b0, i_rst = 1'b1, i_rx_dv = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;
  logic o_rx_dv, o_fifo_sel_1, o_fifo_sel_2, o_busy, o_frame_done, o_frame_err;
  logic [7:0] o_data;
  int n_chk = 0, n_fail = 0;

  always #5 i_clk = ~i_clk;

  rx_frame_router #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_rx_dv(o_rx_dv), .o_data(o_data), .o_fifo_sel_1(o_fifo_sel_1), .o_fifo_sel_2(o_fifo_sel_2),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
  );

  typedef struct {
    logic dv; logic [7:0] b;
    logic e_dv; logic [7:0] e_data; logic e_s1, e_s2, e_busy, e_done, e_err;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(input logic dv, input logic [7:0] b, input logic e_dv, input logic [7:0] e_data,
                              input logic s1, input logic s2, input logic busy, input logic done, input logic err);
    vec_t x;
    x.dv = dv; x.b = b; x.e_dv = e_dv; x.e_data = e_data;
    x.e_s1 = s1; x.e_s2 = s2; x.e_busy = busy; x.e_done = done; x.e_err = err;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic dv, input logic [7:0] b);
    @(negedge i_clk);
    i_rx_dv = dv;
    i_rx_byte = b;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_out(input string tag, input vec_t x);
    chk($sformatf("%s rx_dv", tag), o_rx_dv, x.e_dv);
    if (x.e_dv) chk($sformatf("%s data", tag), o_data, x.e_data);
    chk($sformatf("%s sel_1", tag), o_fifo_sel_1, x.e_s1);
    chk($sformatf("%s sel_2", tag), o_fifo_sel_2, x.e_s2);
    chk($sformatf("%s busy", tag), o_busy, x.e_busy);
    chk($sformatf("%s done", tag), o_frame_done, x.e_done);
    chk($sformatf("%s err", tag), o_frame_err, x.e_err);
  endtask

  task automatic run(input string tag, input vec_t x);
    step(x.dv, x.b);
    check_out(tag, x);
  endtask

  task automatic all_zero(input string tag);
    check_out(tag, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk($sformatf("%s data zero", tag), o_data, 0);
  endtask

  initial begin
    int at, strobes;
    repeat (2) @(posedge i_clk);
    #1 all_zero("reset");
    @(negedge i_clk) i_rst = 1'b0;
`ifndef RX_FRAME_ROUTER_CHECKSUM_EN
    // frame of 3 to weight FIFO
    v.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h03, 0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h11, 1, 8'h11, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h22, 1, 8'h22, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h33, 1, 8'h33, 1, 0, 0, 1, 0));
    v.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    // zero-length data frame
    v.push_back(mk(1, 8'hA2, 0, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 8'h00, 0, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    // junk byte then one-byte data frame
    v.push_back(mk(1, 8'h55, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 8'hA2, 0, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 8'h00, 0, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 8'h01, 0, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 8'h7F, 1, 8'h7F, 0, 1, 0, 1, 0));
    v.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    // oversize 513, trailing byte ignored
    v.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h02, 0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h01, 0, 0, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 8'h10, 0, 0, 0, 0, 0, 0, 0));
    // back-to-back frames: sel hands over from sel_1 to sel_2
    v.push_back(mk(1, 8'hA1, 0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h01, 0, 0, 1, 0, 1, 0, 0));
    v.push_back(mk(1, 8'h44, 1, 8'h44, 1, 0, 0, 1, 0));
    v.push_back(mk(1, 8'hA2, 0, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 8'h00, 0, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    foreach (v[i]) run($sformatf("vec%0d", i), v[i]);
`else
    // checksum good: 10+20 = 30
    run("ck_hdr", mk(1, 8'hA1, 0, 0, 1, 0, 1, 0, 0));
    run("ck_lh", mk(1, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    run("ck_ll", mk(1, 8'h02, 0, 0, 1, 0, 1, 0, 0));
    run("ck_p0", mk(1, 8'h10, 1, 8'h10, 1, 0, 1, 0, 0));
    run("ck_p1", mk(1, 8'h20, 1, 8'h20, 1, 0, 1, 0, 0));
    run("ck_ok", mk(1, 8'h30, 0, 0, 0, 0, 0, 1, 0));
    run("ck2_hdr", mk(1, 8'hA1, 0, 0, 1, 0, 1, 0, 0));
    run("ck2_lh", mk(1, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    run("ck2_ll", mk(1, 8'h02, 0, 0, 1, 0, 1, 0, 0));
    run("ck2_p0", mk(1, 8'h10, 1, 8'h10, 1, 0, 1, 0, 0));
    run("ck2_p1", mk(1, 8'h20, 1, 8'h20, 1, 0, 1, 0, 0));
    run("ck2_bad", mk(1, 8'h31, 0, 0, 0, 0, 0, 0, 1));
`endif
    // length exactly MAX_LEN is accepted
    run("max_hdr", mk(1, 8'hA1, 0, 0, 1, 0, 1, 0, 0));
    run("max_lh", mk(1, 8'h02, 0, 0, 1, 0, 1, 0, 0));
    run("max_ll", mk(1, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    #2 i_rst = 1'b1;
    #1 all_zero("max_rst");
    @(negedge i_clk) i_rst = 1'b0;
    // async reset right after a forwarded payload byte
    run("rst_hdr", mk(1, 8'hA1, 0, 0, 1, 0, 1, 0, 0));
    run("rst_lh", mk(1, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    run("rst_ll", mk(1, 8'h04, 0, 0, 1, 0, 1, 0, 0));
    run("rst_p0", mk(1, 8'h01, 1, 8'h01, 1, 0, 1, 0, 0));
    run("rst_p1", mk(1, 8'h02, 1, 8'h02, 1, 0, 1, 0, 0));
    #2 i_rst = 1'b1;
    #1 all_zero("mid_rst");
    @(negedge i_clk) i_rst = 1'b0;
    // inter-byte timeout
    run("to_hdr", mk(1, 8'hA1, 0, 0, 1, 0, 1, 0, 0));
    run("to_lh", mk(1, 8'h00, 0, 0, 1, 0, 1, 0, 0));
    run("to_ll", mk(1, 8'h04, 0, 0, 1, 0, 1, 0, 0));
    run("to_p0", mk(1, 8'h01, 1, 8'h01, 1, 0, 1, 0, 0));
    run("to_p1", mk(1, 8'h02, 1, 8'h02, 1, 0, 1, 0, 0));
    at = -1;
    strobes = 0;
    for (int k = 1; k <= 3 * TO; k++) begin
      step(0, 8'h00);
      if (o_rx_dv) strobes++;
      if (o_frame_done) begin
        n_chk++; n_fail++;
        $display("FAIL timeout_done: got 1 expected 0 at cycle %0d", k);
      end
      if (o_frame_err) begin
        at = k;
        break;
      end
    end
    chk("timeout_cycle", at, TO);
    chk("timeout_extra_strobes", strobes, 0);
    chk("timeout_sel_1", o_fifo_sel_1, 0);
    step(0, 8'h00);
    chk("timeout_busy", o_busy, 0);
    chk("timeout_err_once", o_frame_err, 0);
    run("post_hdr", mk(1, 8'hA2, 0, 0, 0, 1, 1, 0, 0));
    run("post_lh", mk(1, 8'h00, 0, 0, 0, 1, 1, 0, 0));
    run("post_ll", mk(1, 8'h01, 0, 0, 0, 1, 1, 0, 0));
`ifndef RX_FRAME_ROUTER_CHECKSUM_EN
    run("post_p0", mk(1, 8'h55, 1, 8'h55, 0, 1, 0, 1, 0));
`else
    run("post_p0", mk(1, 8'h55, 1, 8'h55, 0, 1, 1, 0, 0));
    run("post_ck", mk(1, 8'h55, 0, 0, 0, 0, 0, 1, 0));
`endif
    run("post_idle", mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
